// File: rtl/jmp_branch_if.sv
// Decode-to-fetch control-transfer bus for jmp_branch_unit.
// Handshake: the unit samples inst/pc_plus4/rs_data/rt_data only when inst_valid=1 and busy=0; pc_src is a valid held until a cycle with stall=0 (stall acts as not-ready).
interface jmp_branch_if #(
  parameter int ADDR_W = 32
);
  logic              inst_valid;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] pc_plus4;
  logic [31:0]       rs_data;
  logic [31:0]       rt_data;
  logic              stall;
  logic              pc_src;
  logic [ADDR_W-1:0] jmp_addr;
  logic              flush;
  logic              busy;
  logic              link_we;
  logic [ADDR_W-1:0] link_data;

  modport master (
    output inst_valid, inst, pc_plus4, rs_data, rt_data, stall,
    input  pc_src, jmp_addr, flush, busy, link_we, link_data
  );

  modport slave (
    input  inst_valid, inst, pc_plus4, rs_data, rt_data, stall,
    output pc_src, jmp_addr, flush, busy, link_we, link_data
  );
endinterface

// File: rtl/jmp_branch_unit.sv
// Registered J/JAL/JR/BEQ/BNE resolution with held redirect and timed flush window.
// Optional JAL link write port enabled by defining JMP_LINK_EN.
module jmp_branch_unit #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  jmp_branch_if.slave  bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_N = 4'(FLUSH_CYCLES);

  state_t            state;
  logic              pc_src_q;
  logic              flush_q;
  logic              busy_q;
  logic [ADDR_W-1:0] jmp_addr_q;
  logic [3:0]        cnt;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              is_j, is_jal, is_jr, is_beq, is_bne;
  logic              taken;
  logic [31:0]       pc_ext;
  logic [31:0]       j_full;
  logic [31:0]       br_off;
  logic [ADDR_W-1:0] target;

  assign opcode = bus.inst[31:26];
  assign funct  = bus.inst[5:0];
  assign is_j   = (opcode == 6'h02);
  assign is_jal = (opcode == 6'h03);
  assign is_jr  = (opcode == 6'h00) && (funct == 6'h08);
  assign is_beq = (opcode == 6'h04);
  assign is_bne = (opcode == 6'h05);

  // Jump region bits come from pc_plus4 above bit 27; zero-extending first keeps ADDR_W=28 legal.
  assign pc_ext = 32'(bus.pc_plus4);
  assign j_full = {pc_ext[31:28], bus.inst[25:0], 2'b00};
  assign br_off = {{14{bus.inst[15]}}, bus.inst[15:0], 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = '0;
    if (is_j || is_jal) begin
      taken  = 1'b1;
      target = j_full[ADDR_W-1:0];
    end else if (is_jr) begin
      taken  = 1'b1;
      target = bus.rs_data[ADDR_W-1:0];
    end else if (is_beq || is_bne) begin
      taken  = is_beq ? (bus.rs_data == bus.rt_data) : (bus.rs_data != bus.rt_data);
      target = bus.pc_plus4 + br_off[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc_src_q   <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      jmp_addr_q <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inst_valid && taken) begin
            state      <= REDIRECT;
            jmp_addr_q <= target;
            pc_src_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        REDIRECT: begin
          if (!bus.stall) begin
            pc_src_q <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state   <= FLUSH;
              flush_q <= 1'b1;
              cnt     <= FLUSH_N;
            end
          end
        end
        FLUSH: begin
          if (cnt <= 4'd1) begin
            state   <= IDLE;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          pc_src_q <= 1'b0;
          flush_q  <= 1'b0;
          busy_q   <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

  assign bus.pc_src   = pc_src_q;
  assign bus.jmp_addr = jmp_addr_q;
  assign bus.flush    = flush_q;
  assign bus.busy     = busy_q;
  assign dbg_state    = state;

`ifdef JMP_LINK_EN
  logic              link_we_q;
  logic [ADDR_W-1:0] link_data_q;
  logic              link_take;

  // Link write fires only on acceptance, so a stalled redirect never repeats it.
  assign link_take = (state == IDLE) && bus.inst_valid && is_jal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      link_we_q   <= 1'b0;
      link_data_q <= '0;
    end else begin
      link_we_q <= link_take;
      if (link_take) begin
        link_data_q <= bus.pc_plus4;
      end
    end
  end

  assign bus.link_we   = link_we_q;
  assign bus.link_data = link_data_q;
`else
  assign bus.link_we   = 1'b0;
  assign bus.link_data = '0;
`endif

endmodule

// File: tb/tb_jmp_branch_unit.sv
// Bench for jmp_branch_unit: two instances (flush window 1 and 3) driven in lockstep.
module tb_jmp_branch_unit;

  localparam int AW = 32;
`ifdef JMP_LINK_EN
  localparam int          LINK_PULSES = 1;
  localparam logic [31:0] LINK_VAL    = 32'h0000_2004;
`else
  localparam int          LINK_PULSES = 0;
  localparam logic [31:0] LINK_VAL    = 32'h0000_0000;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        inst_valid;
  logic [31:0] inst, pc_plus4, rs_data, rt_data;
  logic        stall;
  logic [1:0]  dbg1, dbg3;

  jmp_branch_if #(.ADDR_W(AW)) if1 ();
  jmp_branch_if #(.ADDR_W(AW)) if3 ();

  assign if1.inst_valid = inst_valid;
  assign if1.inst       = inst;
  assign if1.pc_plus4   = pc_plus4;
  assign if1.rs_data    = rs_data;
  assign if1.rt_data    = rt_data;
  assign if1.stall      = stall;
  assign if3.inst_valid = inst_valid;
  assign if3.inst       = inst;
  assign if3.pc_plus4   = pc_plus4;
  assign if3.rs_data    = rs_data;
  assign if3.rt_data    = rt_data;
  assign if3.stall      = stall;

  jmp_branch_unit #(.ADDR_W(AW), .FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1), .dbg_state(dbg1)
  );
  jmp_branch_unit #(.ADDR_W(AW), .FLUSH_CYCLES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(if3), .dbg_state(dbg3)
  );

  // scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q3[$];
  logic [31:0] cur1, cur3;
  logic        prev1, prev3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev1 = 1'b0;
    end else begin
      if (if1.pc_src && !prev1) begin
        n_cmp++;
        assert (exp_q1.size() != 0) else begin
          n_err++;
          $error("FAIL d1_unexpected_redirect: observed addr=%0h expected=no redirect", if1.jmp_addr);
        end
        if (exp_q1.size() != 0) begin
          cur1 = exp_q1.pop_front();
          check("d1_jmp_addr", if1.jmp_addr, cur1);
        end
      end else if (if1.pc_src) begin
        check("d1_jmp_addr_hold", if1.jmp_addr, cur1);
      end
      prev1 = if1.pc_src;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev3 = 1'b0;
    end else begin
      if (if3.pc_src && !prev3) begin
        n_cmp++;
        assert (exp_q3.size() != 0) else begin
          n_err++;
          $error("FAIL d3_unexpected_redirect: observed addr=%0h expected=no redirect", if3.jmp_addr);
        end
        if (exp_q3.size() != 0) begin
          cur3 = exp_q3.pop_front();
          check("d3_jmp_addr", if3.jmp_addr, cur3);
        end
      end else if (if3.pc_src) begin
        check("d3_jmp_addr_hold", if3.jmp_addr, cur3);
      end
      prev3 = if3.pc_src;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] pc4, input logic [31:0] rs,
                       input logic [31:0] rt, input bit taken, input logic [31:0] tgt);
    inst       = i;
    pc_plus4   = pc4;
    rs_data    = rs;
    rt_data    = rt;
    inst_valid = 1'b1;
    if (taken) begin
      exp_q1.push_back(tgt);
      exp_q3.push_back(tgt);
    end
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_bit({tag, "_d1_pc_src"}, if1.pc_src, 1'b0);
    check_bit({tag, "_d1_busy"},   if1.busy,   1'b0);
    check_bit({tag, "_d3_pc_src"}, if3.pc_src, 1'b0);
    check_bit({tag, "_d3_busy"},   if3.busy,   1'b0);
  endtask

  // Walks one accepted redirect to completion, counting output cycles per instance.
  task automatic run_redirect(input string tag, input int stall_n, input bit inject,
                              input int exp_pc, input int exp_link);
    int pc1, fl1, bz1, pc3, fl3, bz3, lk1, k;
    pc1 = 0; fl1 = 0; bz1 = 0; pc3 = 0; fl3 = 0; bz3 = 0; lk1 = 0; k = 0;
    while ((if1.busy || if3.busy) && k < 40) begin
      pc1 += int'(if1.pc_src);
      fl1 += int'(if1.flush);
      bz1 += int'(if1.busy);
      lk1 += int'(if1.link_we);
      pc3 += int'(if3.pc_src);
      fl3 += int'(if3.flush);
      bz3 += int'(if3.busy);
      stall = (k < stall_n);
      if (inject && k < 2) begin
        inst       = 32'h0800_0123;
        inst_valid = 1'b1;
      end else begin
        inst_valid = 1'b0;
      end
      tick();
      k++;
    end
    stall      = 1'b0;
    inst_valid = 1'b0;
    n_cmp++;
    assert (k < 40) else begin
      n_err++;
      $error("FAIL %s_timeout: observed cycles=%0d required<40", tag, k);
    end
    check({tag, "_d1_pc_cycles"},    pc1, exp_pc);
    check({tag, "_d1_flush_cycles"}, fl1, 1);
    check({tag, "_d1_busy_cycles"},  bz1, exp_pc + 1);
    check({tag, "_d1_link_pulses"},  lk1, exp_link);
    check({tag, "_d3_pc_cycles"},    pc3, exp_pc);
    check({tag, "_d3_flush_cycles"}, fl3, 3);
    check({tag, "_d3_busy_cycles"},  bz3, exp_pc + 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    inst_valid = 1'b0;
    inst       = '0;
    pc_plus4   = '0;
    rs_data    = '0;
    rt_data    = '0;
    stall      = 1'b0;
    tick();
    check_bit("rst_pc_src",  if1.pc_src,  1'b0);
    check_bit("rst_flush",   if1.flush,   1'b0);
    check_bit("rst_busy",    if1.busy,    1'b0);
    check_bit("rst_link_we", if1.link_we, 1'b0);
    check("rst_jmp_addr",    if1.jmp_addr,  32'h0);
    check("rst_link_data",   if1.link_data, 32'h0);
    check("rst_state",       32'(dbg1),     32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // J into same 256MB region
    issue(32'h0800_0040, 32'h1000_0004, 32'h0, 32'h0, 1'b1, 32'h1000_0100);
    run_redirect("j", 0, 1'b0, 1, 0);

    // BEQ backwards by one word, then the untaken variant
    issue(32'h1000_FFFF, 32'h0000_0010, 32'd5, 32'd5, 1'b1, 32'h0000_000C);
    run_redirect("beq", 0, 1'b0, 1, 0);
    issue(32'h1000_FFFF, 32'h0000_0010, 32'd5, 32'd6, 1'b0, 32'h0);
    check_quiet("beq_nt");
    tick();
    check_quiet("beq_nt2");

    // JR held by three stall cycles
    issue(32'h03E0_0008, 32'h0000_0400, 32'h0040_0020, 32'h0, 1'b1, 32'h0040_0020);
    run_redirect("jr_stall", 3, 1'b0, 4, 0);

    // BNE wrapping past 2^32, with a J offered while busy
    issue(32'h1400_0003, 32'hFFFF_FFFC, 32'd1, 32'd2, 1'b1, 32'h0000_0008);
    run_redirect("bne_inject", 0, 1'b1, 1, 0);
    issue(32'h1400_0003, 32'hFFFF_FFFC, 32'd7, 32'd7, 1'b0, 32'h0);
    check_quiet("bne_nt");

    // JALR and ADDI are not control transfers for this unit
    issue(32'h03E0_0009, 32'h0000_0100, 32'h0000_0200, 32'h0, 1'b0, 32'h0);
    check_quiet("jalr");
    issue(32'h2000_0000, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 32'h0);
    check_quiet("addi");

    // JAL with a two-cycle stall; link pulse must not repeat
    issue(32'h0C00_0800, 32'h0000_2004, 32'h0, 32'h0, 1'b1, 32'h0000_2000);
    run_redirect("jal", 2, 1'b0, 3, LINK_PULSES);
    check("jal_link_data", if1.link_data, LINK_VAL);
    check_bit("jal_link_we_after", if1.link_we, 1'b0);

    // asynchronous reset while a stalled redirect is pending
    issue(32'h0800_0040, 32'h2000_0004, 32'h0, 32'h0, 1'b1, 32'h2000_0100);
    stall = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_bit("arst_d1_pc_src", if1.pc_src, 1'b0);
    check_bit("arst_d1_flush",  if1.flush,  1'b0);
    check_bit("arst_d1_busy",   if1.busy,   1'b0);
    check("arst_d1_jmp_addr",   if1.jmp_addr, 32'h0);
    check("arst_d1_state",      32'(dbg1),    32'h0);
    check_bit("arst_d3_pc_src", if3.pc_src, 1'b0);
    check_bit("arst_d3_busy",   if3.busy,   1'b0);
    check("arst_d3_state",      32'(dbg3),    32'h0);
    tick();
    stall   = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_quiet("post_arst");
    end

    check("q1_empty", exp_q1.size(), 32'h0);
    check("q3_empty", exp_q3.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jmp_branch_unit.md
# jmp_branch_unit

Registered control-transfer resolution unit for the pipelined MIPS core, sitting between decode and the fetch PC mux. It decodes J, JAL, JR, BEQ and BNE, computes the target at a parametrised address width, and issues a one-shot redirect. The redirect is held across fetch stalls and followed by a programmable-length flush window. It replaces the single-opcode combinational jump detector with a sequenced redirect/flush handshake.

## Interface
Parameters:
- ADDR_W, 32, PC/target width; legal range 28..32
- FLUSH_CYCLES, 1, cycles `flush` stays high after a redirect is accepted; 0..15

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- inst_valid  in  1  `inst` holds a valid decoded-stage instruction this cycle
- inst  in  32  instruction word
- pc_plus4  in  ADDR_W  PC+4 of `inst`
- rs_data  in  32  forwarded rs value, used for JR target and branch compare
- rt_data  in  32  forwarded rt value, used for branch compare
- stall  in  1  fetch cannot take a redirect this cycle
- pc_src  out  1  redirect valid; fetch loads `jmp_addr`
- jmp_addr  out  ADDR_W  registered redirect target
- flush  out  1  squash IF/ID contents
- busy  out  1  unit not IDLE; new instructions are ignored
- link_we  out  1  JAL link write strobe (macro-dependent)
- link_data  out  ADDR_W  link value, equal to pc_plus4 of the JAL

## Operation
- Decode, evaluated only when `inst_valid` is high and the state is IDLE:
  - J: opcode 0x02.
  - JAL: opcode 0x03.
  - JR: opcode 0x00 with funct 0x08.
  - BEQ: opcode 0x04, taken if rs_data==rt_data.
  - BNE: opcode 0x05, taken if rs_data!=rt_data.
  - Anything else, or an untaken branch, is not taken.
- Targets, all truncated to ADDR_W:
  - J/JAL: {pc_plus4[ADDR_W-1:28], inst[25:0], 2'b00}.
  - JR: rs_data[ADDR_W-1:0].
  - Branch: pc_plus4 + (sign-extended inst[15:0] << 2), with wrap-around modulo 2^ADDR_W.
- FSM:
  - IDLE: a taken transfer latches `jmp_addr` and moves to REDIRECT.
  - REDIRECT: `pc_src`=1. If `stall`=1, stay and hold `jmp_addr`. If `stall`=0, go to FLUSH with count=FLUSH_CYCLES, or to IDLE when FLUSH_CYCLES=0.
  - FLUSH: `flush`=1, count decrements each cycle, return to IDLE after the cycle in which count==1.
- `busy` is high in REDIRECT and FLUSH. `inst_valid` is ignored while busy; such instructions are never redirected.
- `jmp_addr` changes only on IDLE→REDIRECT. Otherwise it holds its last value.

## Timing
- Reset values: `pc_src`=0, `flush`=0, `busy`=0, `link_we`=0, `jmp_addr`=0, `link_data`=0. State is IDLE.
- A taken instruction sampled at edge N gives `pc_src`=1 from N+1. Latency is 1 cycle, with no combinational path from `inst` to outputs.
- `pc_src` is high for exactly 1 cycle if `stall`=0, else 1+(stall cycles).
- `flush` is high for exactly FLUSH_CYCLES consecutive cycles, starting the cycle after the last `pc_src` cycle.
- Back-to-back taken transfers are separated by at least 1+FLUSH_CYCLES cycles of `busy`.
- Asserting `reset_n` low mid-REDIRECT or mid-FLUSH forces all outputs to reset values immediately, without waiting for a clock edge. The pending redirect is discarded.
- `stall` in IDLE or FLUSH has no effect.

## Configuration
- JMP_LINK_EN defined:
  - A JAL sampled in IDLE pulses `link_we` for 1 cycle, concurrent with the first `pc_src` cycle.
  - `link_data`=pc_plus4 of the JAL, registered at the same edge.
  - `link_we` is not repeated during stall.
- JMP_LINK_EN undefined:
  - JAL behaves exactly as J.
  - `link_we` and `link_data` are tied to 0.

## Test plan
- ADDR_W=32, FLUSH_CYCLES=1. J with inst=0x0800_0040, pc_plus4=0x1000_0004 → next cycle pc_src=1, jmp_addr=0x1000_0100; then flush=1 for 1 cycle; busy for 2 cycles total.
- BEQ with imm=0xFFFF, pc_plus4=0x0000_0010, rs=rt=5 → jmp_addr=0x0000_000C. Same instruction with rt=6 → pc_src stays 0 and busy stays 0.
- JR with rs_data=0x0040_0020 and stall held 3 cycles → pc_src=1 for 4 cycles with jmp_addr stable; then flush for FLUSH_CYCLES cycles.
- FLUSH_CYCLES=3, BNE taken, second J presented while busy → only the first redirect occurs; flush=1 for exactly 3 cycles.
- reset_n driven low during REDIRECT with stall=1 → pc_src, flush and busy drop to 0 with no clock edge. After release, no redirect occurs.
- With JMP_LINK_EN, JAL at pc_plus4=0x0000_2004 → link_we single pulse with link_data=0x0000_2004. Without the macro → link_we stays 0 and the redirect matches J.
